// File: rtl/test_completion_monitor_pkg.sv
// rtl/test_completion_monitor_pkg.sv - shared state encodings and tohost constants for the completion monitor
package test_completion_monitor_pkg;

    // Run state of the monitored program; everything but ST_RUN is terminal until reset.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } tcm_state_e;

    // Value the program stores to tohost to report success.
    localparam logic [31:0] TOHOST_PASS = 32'h0000_0001;

    // A tohost store ends the run only when bit 0 is set; even values are ordinary traffic.
    function automatic logic is_terminating(input logic we, input logic at_tohost,
                                            input logic [31:0] wdata);
        return we && at_tohost && wdata[0];
    endfunction

endpackage

// File: rtl/test_completion_monitor_if.sv
// rtl/test_completion_monitor_if.sv - core data-memory write port as observed by the completion monitor
interface test_completion_monitor_if;

    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    // The core drives the write port.
    modport master (
        output we,
        output addr,
        output wdata
    );

    // The monitor only snoops it.
    modport slave (
        input we,
        input addr,
        input wdata
    );

endinterface

// File: rtl/tcm_sig_buf.sv
// rtl/tcm_sig_buf.sv - signature word buffer with per-word valid bits and registered read
module tcm_sig_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0]      words_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Valid bits track which words were written since reset, so stale data never leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Word storage needs no reset because the valid bits mask it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            words_q[wr_idx] <= wr_data;
        end
    end

    // Registered read; unwritten words read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 32'h0;
        end else begin
            rd_data <= valid_q[rd_idx] ? words_q[rd_idx] : 32'h0;
        end
    end

endmodule

// File: rtl/test_completion_monitor.sv
// rtl/test_completion_monitor.sv - tohost/watchdog run-end checker; SIG_CAPTURE_EN adds signature capture
module test_completion_monitor
    import test_completion_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FF0,
    parameter int          TIMEOUT_CYC = 1000,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] SIG_BASE    = 32'h0000_0F00,
    parameter int          SIG_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    test_completion_monitor_if.slave     mem,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [30:0]                  exit_code,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             store_count,
    input  logic [$clog2(SIG_DEPTH)-1:0] sig_idx,
    output logic [31:0]                  sig_data
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    tcm_state_e state_q, state_d;
    logic       running;
    logic       term_store;
    logic       wdog_fire;

    assign running    = (state_q == ST_RUN);
    assign term_store = is_terminating(mem.we, mem.addr == TOHOST_ADDR, mem.wdata);
    assign wdog_fire  = (cycle_count == TIMEOUT_LAST);

    // State register; terminal states hold until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a terminating store takes priority over the watchdog on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (term_store) begin
                    state_d = (mem.wdata == TOHOST_PASS) ? ST_PASS : ST_FAIL;
                end else if (wdog_fire) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Flags decode straight from the state register, so they are registered and mutually exclusive.
    assign done    = !running;
    assign pass    = (state_q == ST_PASS);
    assign fail    = (state_q == ST_FAIL);
    assign timeout = (state_q == ST_TIMEOUT);

    // Saturating cycle and store counters, frozen once the run has ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            store_count <= '0;
        end else if (running) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (mem.we && (store_count != '1)) begin
                store_count <= store_count + 1'b1;
            end
        end
    end

    // Exit code latched only from the store that ends the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exit_code <= '0;
        end else if (running && term_store) begin
            exit_code <= mem.wdata[31:1];
        end
    end

`ifdef SIG_CAPTURE_EN
    localparam int          SIG_AW  = $clog2(SIG_DEPTH);
    localparam logic [31:0] SIG_END = SIG_BASE + 32'(4 * SIG_DEPTH);

    logic              sig_wr;
    logic [SIG_AW-1:0] sig_word;

    assign sig_wr   = running && mem.we && (mem.addr >= SIG_BASE) && (mem.addr < SIG_END);
    assign sig_word = SIG_AW'((mem.addr - SIG_BASE) >> 2);

    tcm_sig_buf #(
        .DEPTH (SIG_DEPTH)
    ) u_sig_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sig_wr),
        .wr_idx  (sig_word),
        .wr_data (mem.wdata),
        .rd_idx  (sig_idx),
        .rd_data (sig_data)
    );
`else
    logic sig_unused;

    assign sig_unused = ^{sig_idx, SIG_BASE};
    assign sig_data   = 32'h0;
`endif

endmodule

// File: tb/tb_test_completion_monitor.sv
// tb/tb_test_completion_monitor.sv - directed self-checking bench for the completion monitor
module tb_test_completion_monitor;

    localparam logic [31:0] TOHOST = 32'h0000_0FF0;
    localparam logic [31:0] SIGB   = 32'h0000_0F00;

    logic        clk;
    logic        rst;
    logic        done, pass, fail, timeout;
    logic [30:0] exit_code;
    logic [31:0] cycle_count, store_count;
    logic [3:0]  sig_idx;
    logic [31:0] sig_data;
    logic [31:0] sig_expect;

    int checks   = 0;
    int failures = 0;

    test_completion_monitor_if mif ();

    test_completion_monitor #(
        .TOHOST_ADDR (TOHOST),
        .TIMEOUT_CYC (20),
        .CNT_W       (32),
        .SIG_BASE    (SIGB),
        .SIG_DEPTH   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mif.slave),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .cycle_count (cycle_count),
        .store_count (store_count),
        .sig_idx     (sig_idx),
        .sig_data    (sig_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mif.we    = 1'b1;
        mif.addr  = a;
        mif.wdata = d;
        tick(1);
        mif.we    = 1'b0;
        mif.addr  = 32'h0;
        mif.wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp_dpft);
        check(tag, {28'h0, done, pass, fail, timeout}, {28'h0, exp_dpft});
    endtask

    initial begin
        rst       = 1'b1;
        mif.we    = 1'b0;
        mif.addr  = 32'h0;
        mif.wdata = 32'h0;
        sig_idx   = 4'd0;
        tick(2);

        // Reset state
        check_flags("reset_flags", 4'b0000);
        check("reset_cycles", cycle_count, 32'd0);
        check("reset_stores", store_count, 32'd0);
        check("reset_exit", {1'b0, exit_code}, 32'd0);
        check("reset_sig", sig_data, 32'd0);

        // 1: pass at cycle 5
        rst = 1'b0;
        tick(5);
        check("t1_cycle5", cycle_count, 32'd5);
        check_flags("t1_running", 4'b0000);
        store(TOHOST, 32'h1);
        check_flags("t1_pass", 4'b1100);
        check("t1_exit", {1'b0, exit_code}, 32'd0);
        check("t1_cycle6", cycle_count, 32'd6);
        check("t1_stores", store_count, 32'd1);
        tick(3);
        check("t1_frozen", cycle_count, 32'd6);
        check_flags("t1_sticky", 4'b1100);

        // 2: even tohost value is ordinary, odd value fails, later stores ignored
        do_reset();
        store(TOHOST, 32'h2);
        check_flags("t2_even_ignored", 4'b0000);
        check("t2_even_counted", store_count, 32'd1);
        store(TOHOST, 32'h7);
        check_flags("t2_fail", 4'b1010);
        check("t2_exit", {1'b0, exit_code}, 32'd3);
        check("t2_stores", store_count, 32'd2);
        check("t2_cycle", cycle_count, 32'd2);
        store(TOHOST, 32'h1);
        check_flags("t2_after_done", 4'b1010);
        check("t2_exit_hold", {1'b0, exit_code}, 32'd3);
        check("t2_stores_hold", store_count, 32'd2);
        check("t2_cycle_hold", cycle_count, 32'd2);

        // 3: watchdog
        do_reset();
        tick(19);
        check_flags("t3_before", 4'b0000);
        check("t3_cycle19", cycle_count, 32'd19);
        tick(1);
        check_flags("t3_timeout", 4'b1001);
        check("t3_cycle20", cycle_count, 32'd20);
        tick(2);
        check("t3_frozen", cycle_count, 32'd20);
        check("t3_exit", {1'b0, exit_code}, 32'd0);

        // 4: terminating store on the watchdog cycle wins
        do_reset();
        tick(19);
        check("t4_cycle19", cycle_count, 32'd19);
        store(TOHOST, 32'h1);
        check_flags("t4_pass_wins", 4'b1100);
        check("t4_cycle20", cycle_count, 32'd20);

        // 5: mid-run reset
        do_reset();
        mif.we   = 1'b1;
        mif.addr = 32'h0000_0100;
        tick(10);
        mif.we   = 1'b0;
        mif.addr = 32'h0;
        check("t5_cycle10", cycle_count, 32'd10);
        check("t5_stores10", store_count, 32'd10);
        rst = 1'b1;
        #1;
        check("t5_async_cycles", cycle_count, 32'd0);
        check("t5_async_stores", store_count, 32'd0);
        check_flags("t5_async_flags", 4'b0000);
        tick(2);
        check("t5_held", cycle_count, 32'd0);
        rst = 1'b0;
        tick(3);
        check("t5_restart", cycle_count, 32'd3);
        check("t5_restart_stores", store_count, 32'd0);

        // 6: signature capture
        do_reset();
        store(SIGB + 32'd8, 32'hDEAD_BEEF);
        sig_idx = 4'd2;
        tick(1);
`ifdef SIG_CAPTURE_EN
        sig_expect = 32'hDEAD_BEEF;
`else
        sig_expect = 32'h0;
`endif
        check("t6_sig_word2", sig_data, sig_expect);
        sig_idx = 4'd3;
        tick(1);
        check("t6_sig_word3", sig_data, 32'h0);
        check_flags("t6_running", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
